// File: rtl/axi_burst_ram_slave.sv
// axi_burst_ram_slave: AXI4 full slave over a dual-port word RAM.
// FIXED/INCR/WRAP bursts up to 256 beats, byte strobes, independent
// read and write channels. Optional macro AXI_SLV_ERR_RESP_EN enables
// SLVERR on out-of-range beats and on WLAST/counter disagreement.
module axi_burst_ram_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int MEM_DEPTH          = 64
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int          ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
    localparam int          IDX_W    = $clog2(MEM_DEPTH);
    localparam int unsigned NBYTES   = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic                        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
    logic                        aw_hs, w_hs, ar_hs, r_hs, w_wen;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id, r_id;
    logic [IDX_W-1:0]            w_idx, r_idx, r_nidx, ar_idx;
    logic [7:0]                  w_len, w_cnt, r_len, r_cnt;
    logic [1:0]                  w_burst, r_burst;
    logic [2:0]                  w_size, r_size;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_data;

    // Next word index for a burst; WRAP only for legal lengths, else INCR.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] a,
                                                  input logic [7:0]       len,
                                                  input logic [1:0]       burst);
        logic [IDX_W-1:0] m;
        logic [IDX_W-1:0] inc;
        logic [IDX_W-1:0] res;
        m   = IDX_W'(len);
        inc = a + 1'b1;
        res = inc;
        if (burst == 2'b00)
            res = a;
        else if (burst == 2'b10 &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            res = (a & ~m) | (inc & m);
        return res;
    endfunction

    assign aw_hs  = S_AXI_AWVALID && aw_ready;
    assign w_hs   = S_AXI_WVALID  && w_ready;
    assign ar_hs  = S_AXI_ARVALID && ar_ready;
    assign r_hs   = S_AXI_RREADY  && r_valid;
    assign ar_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign r_nidx = next_idx(r_idx, r_len, r_burst);
    assign r_last = (r_state == R_DATA) && (r_cnt == r_len);

`ifdef AXI_SLV_ERR_RESP_EN
    logic       w_oor, w_err, r_oor;
    logic [1:0] r_resp;
    assign w_wen       = w_hs && !w_oor;
    assign S_AXI_BRESP = w_err ? 2'b10 : 2'b00;
    assign S_AXI_RRESP = r_resp;
`else
    assign w_wen       = w_hs;
    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
`endif

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BID     = w_id;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RID     = r_id;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RLAST   = r_last;

    // Sideband and address bits not consumed by the datapath.
    logic unused_sigs;
    assign unused_sigs = ^{S_AXI_WLAST, S_AXI_AWADDR, S_AXI_ARADDR, w_size, r_size};

    // Write FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) w_state <= W_IDLE;
        else              w_state <= w_next;
    end

    // Write FSM next state and handshake outputs; READYs masked during reset.
    always_comb begin
        w_next   = w_state;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_ready = !S_AXI_ARESET;
                if (S_AXI_AWVALID && aw_ready) w_next = W_DATA;
            end
            W_DATA: begin
                w_ready = !S_AXI_ARESET;
                if (S_AXI_WVALID && w_ready && w_cnt == w_len) w_next = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write request latch, beat counter and address advance.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_size  <= '0;
            w_cnt   <= '0;
`ifdef AXI_SLV_ERR_RESP_EN
            w_oor   <= 1'b0;
            w_err   <= 1'b0;
`endif
        end else if (aw_hs) begin
            w_id    <= S_AXI_AWID;
            w_idx   <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
            w_len   <= S_AXI_AWLEN;
            w_burst <= S_AXI_AWBURST;
            w_size  <= S_AXI_AWSIZE;
            w_cnt   <= '0;
`ifdef AXI_SLV_ERR_RESP_EN
            w_oor   <= (S_AXI_AWADDR >> (ADDR_LSB + IDX_W)) != '0;
            w_err   <= 1'b0;
`endif
        end else if (w_hs) begin
            w_cnt <= w_cnt + 1'b1;
            w_idx <= next_idx(w_idx, w_len, w_burst);
`ifdef AXI_SLV_ERR_RESP_EN
            if (w_oor || (S_AXI_WLAST != (w_cnt == w_len))) w_err <= 1'b1;
`endif
        end
    end

    // RAM write port with byte enables; contents are never reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_wen) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (S_AXI_WSTRB[i]) mem[w_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_state <= R_IDLE;
        else              r_state <= r_next;
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        r_next   = r_state;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready = !S_AXI_ARESET;
                if (S_AXI_ARVALID && ar_ready) r_next = R_DATA;
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (S_AXI_RREADY && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read request latch and RAM read port; the next word is fetched on each
    // non-final handshake so RVALID stays high and RDATA holds while stalled.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_size  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
`ifdef AXI_SLV_ERR_RESP_EN
            r_oor   <= 1'b0;
            r_resp  <= 2'b00;
`endif
        end else if (ar_hs) begin
            r_id    <= S_AXI_ARID;
            r_idx   <= ar_idx;
            r_len   <= S_AXI_ARLEN;
            r_burst <= S_AXI_ARBURST;
            r_size  <= S_AXI_ARSIZE;
            r_cnt   <= '0;
            r_data  <= mem[ar_idx];
`ifdef AXI_SLV_ERR_RESP_EN
            r_oor   <= (S_AXI_ARADDR >> (ADDR_LSB + IDX_W)) != '0;
            r_resp  <= 2'b00;
            if ((S_AXI_ARADDR >> (ADDR_LSB + IDX_W)) != '0) begin
                r_data <= '0;
                r_resp <= 2'b10;
            end
`endif
        end else if (r_hs && !r_last) begin
            r_cnt  <= r_cnt + 1'b1;
            r_idx  <= r_nidx;
            r_data <= mem[r_nidx];
`ifdef AXI_SLV_ERR_RESP_EN
            if (r_oor) r_data <= '0;
`endif
        end
    end

endmodule
